// File: rtl/red_pitaya_pfd_freq_block.sv
// Phase unwrapper and gated frequency counter behind the CORDIC phase detector.
// Differences the phase word, integrates over a 2^loggate gate, and exposes results on the PS bus.
module red_pitaya_pfd_freq_block #(
  parameter int unsigned SIGNALBITS = 14,
  parameter int unsigned PHASEWIDTH = 12,
  parameter int unsigned ACCWIDTH   = 32,
  parameter int unsigned LOGGATEMAX = 20
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic [SIGNALBITS-1:0]        phase_i,
  output logic signed [SIGNALBITS-1:0] freq_o,
  output logic                         freq_valid_o,
  input  logic [15:0]                  addr,
  input  logic                         wen,
  input  logic                         ren,
  output logic                         ack,
  output logic [31:0]                  rdata,
  input  logic [31:0]                  wdata
);

  localparam logic signed [ACCWIDTH-1:0] SatMax = ACCWIDTH'((2 ** (SIGNALBITS - 1)) - 1);
  localparam logic signed [ACCWIDTH-1:0] SatMin = -SatMax;

  logic [PHASEWIDTH-1:0] p_q, p_d, pp_q, pp_d;
  logic                  loaded_q, loaded_d, prime_q, prime_d;
  logic [ACCWIDTH-1:0]   acc_q, acc_d, cnt_q, cnt_d, tot_q, tot_d, freq_lat_q, freq_lat_d;
  logic [15:0]           rcnt_q, rcnt_d;
  logic [4:0]            loggate_q, loggate_d, shift_q, shift_d;
  logic signed [SIGNALBITS-1:0] freq_d;
  logic                  freq_valid_d, ack_d;
  logic [31:0]           rdata_d;

  logic [PHASEWIDTH-1:0]       d_raw;
  logic signed [ACCWIDTH-1:0]  d_ext, acc_sum, shifted;
  logic signed [SIGNALBITS-1:0] sat_val;
  logic [ACCWIDTH-1:0]         gate_last;

  // Modular difference read as signed gives the unwrapped step across 4095->0.
  assign d_raw     = p_q - pp_q;
  assign d_ext     = prime_q ? {{(ACCWIDTH - PHASEWIDTH){d_raw[PHASEWIDTH-1]}}, d_raw} : '0;
  assign acc_sum   = acc_q + d_ext;
  assign shifted   = acc_sum >>> shift_q;
  assign gate_last = (ACCWIDTH'(1) << loggate_q) - ACCWIDTH'(1);

  always_comb begin
    sat_val = shifted[SIGNALBITS-1:0];
    if (shifted > SatMax) begin
      sat_val = SatMax[SIGNALBITS-1:0];
    end else if (shifted < SatMin) begin
      sat_val = SatMin[SIGNALBITS-1:0];
    end
  end

  always_comb begin
    p_d          = phase_i[PHASEWIDTH-1:0];
    pp_d         = p_q;
    loaded_d     = 1'b1;
    prime_d      = loaded_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    tot_d        = tot_q;
    freq_lat_d   = freq_lat_q;
    rcnt_d       = rcnt_q;
    loggate_d    = loggate_q;
    shift_d      = shift_q;
    freq_d       = freq_o;
    freq_valid_d = 1'b0;
    ack_d        = wen | ren;
    rdata_d      = rdata;

    if (prime_q) begin
      acc_d = acc_sum;
      cnt_d = cnt_q + ACCWIDTH'(1);
      tot_d = tot_q + d_ext;
      if (cnt_q == gate_last) begin
        freq_lat_d   = acc_sum;
        freq_d       = sat_val;
        freq_valid_d = 1'b1;
        rcnt_d       = rcnt_q + 16'd1;
        acc_d        = '0;
        cnt_d        = '0;
      end
    end

    if (wen) begin
      case (addr)
        16'h0000: begin
          // Gate restart overrides any result that would latch this cycle.
          loggate_d    = (wdata[4:0] > 5'(LOGGATEMAX)) ? 5'(LOGGATEMAX) : wdata[4:0];
          acc_d        = '0;
          cnt_d        = '0;
          loaded_d     = 1'b0;
          prime_d      = 1'b0;
          freq_lat_d   = freq_lat_q;
          freq_d       = freq_o;
          freq_valid_d = 1'b0;
          rcnt_d       = rcnt_q;
        end
        16'h0004: shift_d = wdata[4:0];
        16'h000C: tot_d = '0;
        default: ;
      endcase
    end

    if (ren) begin
      case (addr)
        16'h0000: rdata_d = {27'd0, loggate_d};
        16'h0004: rdata_d = {27'd0, shift_d};
        16'h0008: rdata_d = 32'($signed(freq_lat_q));
        16'h000C: rdata_d = (wen && addr == 16'h000C) ? 32'd0 : 32'(tot_q);
        16'h0010: rdata_d = {16'd0, rcnt_q};
        default:  rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      p_q          <= '0;
      pp_q         <= '0;
      loaded_q     <= 1'b0;
      prime_q      <= 1'b0;
      acc_q        <= '0;
      cnt_q        <= '0;
      tot_q        <= '0;
      freq_lat_q   <= '0;
      rcnt_q       <= '0;
      loggate_q    <= 5'd10;
      shift_q      <= '0;
      freq_o       <= '0;
      freq_valid_o <= 1'b0;
      ack          <= 1'b0;
      rdata        <= '0;
    end else begin
      p_q          <= p_d;
      pp_q         <= pp_d;
      loaded_q     <= loaded_d;
      prime_q      <= prime_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      tot_q        <= tot_d;
      freq_lat_q   <= freq_lat_d;
      rcnt_q       <= rcnt_d;
      loggate_q    <= loggate_d;
      shift_q      <= shift_d;
      freq_o       <= freq_d;
      freq_valid_o <= freq_valid_d;
      ack          <= ack_d;
      rdata        <= rdata_d;
    end
  end

endmodule

// File: tb/tb_red_pitaya_pfd_freq_block.sv
// Directed bench for red_pitaya_pfd_freq_block: phase ramps, gate timing, register map, reset.
module tb_red_pitaya_pfd_freq_block;

  logic               clk = 1'b0;
  logic               rstn;
  logic [13:0]        phase = 14'd0;
  logic [13:0]        step = 14'd1;
  logic signed [13:0] freq;
  logic               freq_valid;
  logic [15:0]        addr;
  logic               wen, ren, ack;
  logic [31:0]        rdata, wdata;

  int tests = 0;
  int fails = 0;
  int n;
  logic [31:0] r, r2;

  red_pitaya_pfd_freq_block dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .phase_i     (phase),
    .freq_o      (freq),
    .freq_valid_o(freq_valid),
    .addr        (addr),
    .wen         (wen),
    .ren         (ren),
    .ack         (ack),
    .rdata       (rdata),
    .wdata       (wdata)
  );

  always #5 clk = ~clk;

  // Phase advances by step every cycle; turns bits roll over freely.
  initial forever begin
    @(negedge clk);
    phase = phase + step;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; wen = 1'b1;
    @(posedge clk); #1;
    wen = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; ren = 1'b1;
    @(posedge clk); #1;
    ren = 1'b0;
    check("ack", {31'd0, ack}, 32'd1);
    d = rdata;
  endtask

  task automatic wait_strobe(input int max, output int cycles);
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
    end while (!freq_valid && cycles < max);
  endtask

  initial begin
    rstn = 1'b0; wen = 1'b0; ren = 1'b0; addr = 16'd0; wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_freq", {18'd0, freq}, 32'd0);
    check("rst_valid", {31'd0, freq_valid}, 32'd0);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    @(negedge clk) rstn = 1'b1;
    bus_read(16'h0000, r); check("rst_loggate", r, 32'd10);
    bus_read(16'h0004, r); check("rst_shift", r, 32'd0);
    bus_read(16'h0010, r); check("rst_rcnt", r, 32'd0);
    @(posedge clk); #1;
    check("ack_drop", {31'd0, ack}, 32'd0);

    // +1 ramp, gate 16
    step = 14'd1;
    bus_write(16'h0000, 32'd4);
    wait_strobe(40, n); check("ramp1_lat", n, 32'd18);
    check("ramp1_freq", {18'd0, freq}, 32'd16);
    bus_read(16'h0008, r); check("ramp1_lat_reg", r, 32'd16);
    bus_read(16'h0010, r); check("ramp1_rcnt1", r, 32'd1);
    wait_strobe(40, n); check("ramp1_period", n, 32'd14);
    bus_read(16'h0010, r); check("ramp1_rcnt2", r, 32'd2);
    repeat (3) @(posedge clk);
    #1;
    check("hold_valid", {31'd0, freq_valid}, 32'd0);
    check("hold_freq", {18'd0, freq}, 32'd16);

    // Restart written exactly on the terminal-count cycle
    wait_strobe(40, n); check("ramp1_period2", n, 32'd12);
    repeat (15) @(posedge clk);
    bus_write(16'h0000, 32'd4);
    check("restart_no_strobe", {31'd0, freq_valid}, 32'd0);
    wait_strobe(40, n); check("restart_lat", n, 32'd18);
    check("restart_freq", {18'd0, freq}, 32'd16);
    bus_read(16'h0010, r); check("restart_rcnt", r, 32'd4);

    // Total clear
    bus_write(16'h000C, 32'hDEAD_BEEF);
    bus_read(16'h000C, r); check("tot_clear", r, 32'd0);
    bus_read(16'h000C, r); check("tot_after_clear", r, 32'd1);

    // +100 ramp wrapping through 4095->0, gate 8
    step = 14'd100;
    bus_write(16'h0000, 32'd3);
    wait_strobe(40, n); check("ramp100_lat", n, 32'd10);
    check("ramp100_freq1", {18'd0, freq}, 32'd800);
    wait_strobe(40, n); check("ramp100_period", n, 32'd8);
    check("ramp100_freq2", {18'd0, freq}, 32'd800);
    bus_read(16'h000C, r);
    bus_read(16'h000C, r2);
    check("ramp100_tot_step", r2 - r, 32'd100);

    // -3 ramp, gate 4
    step = 14'h3FFD;
    bus_write(16'h0000, 32'd2);
    wait_strobe(40, n); check("ramp_m3_lat", n, 32'd6);
    check("ramp_m3_freq", {18'd0, freq}, 32'h3FF4);
    bus_read(16'h0008, r); check("ramp_m3_lat_reg", r, 32'hFFFF_FFF4);

    // +2047 steps: saturation, then shift
    step = 14'd2047;
    bus_write(16'h0000, 32'd4);
    wait_strobe(40, n); check("big_lat", n, 32'd18);
    check("big_sat", {18'd0, freq}, 32'd8191);
    bus_read(16'h0008, r); check("big_lat_reg", r, 32'd32752);
    bus_write(16'h0004, 32'd2);
    check("shift_no_rescale", {18'd0, freq}, 32'd8191);
    wait_strobe(40, n); check("shift_strobe", {31'd0, freq_valid}, 32'd1);
    check("shift_freq", {18'd0, freq}, 32'd8188);

    // wen+ren together, clamp, unmapped address
    @(negedge clk);
    addr = 16'h0004; wdata = 32'd5; wen = 1'b1; ren = 1'b1;
    @(posedge clk); #1;
    wen = 1'b0; ren = 1'b0;
    check("wr_rd_same", rdata, 32'd5);
    bus_write(16'h0000, 32'd31);
    bus_read(16'h0000, r); check("loggate_clamp", r, 32'd20);
    bus_write(16'h0020, 32'd7);
    bus_read(16'h0014, r); check("unmapped_rd", r, 32'd0);
    bus_read(16'h0004, r); check("unmapped_wr", r, 32'd5);

    // Mid-gate reset with continuous +1 ramp
    step = 14'd1;
    @(negedge clk) rstn = 1'b0;
    #1;
    check("mid_rst_freq", {18'd0, freq}, 32'd0);
    check("mid_rst_valid", {31'd0, freq_valid}, 32'd0);
    check("mid_rst_rdata", rdata, 32'd0);
    check("mid_rst_ack", {31'd0, ack}, 32'd0);
    @(negedge clk) rstn = 1'b1;
    wait_strobe(1200, n); check("post_rst_lat", n, 32'd1026);
    check("post_rst_freq", {18'd0, freq}, 32'd1024);
    bus_read(16'h0000, r); check("post_rst_loggate", r, 32'd10);
    bus_read(16'h0004, r); check("post_rst_shift", r, 32'd0);
    bus_read(16'h0010, r); check("post_rst_rcnt", r, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
